pe_trace_capture: RTL and testbench
===================================

Name: pe_trace_capture

Overview:
- Synthesizable, parametrised trace unit that watches NUM_CH PE_Outport0 token buses in the PE array.
- A token qualifies when vbl is non-zero and the control flag is clear. Each qualifying token is captured with its channel id and a cycle timestamp.
- Captures are merged through a round-robin arbiter into a FIFO, which a host or debug bridge drains over a valid/ready port.
- This replaces the simulation-only per-PE $fwrite logging with hardware that can sit on silicon/FPGA.

Parameters:
- NUM_CH, 8, number of monitored 36-bit token buses (1..32)
- DEPTH, 64, trace FIFO entries (power of two, >=2)
- TS_W, 16, timestamp width
- CH_W, $clog2(NUM_CH) (minimum 1), channel-id width (derived localparam)
- REC_W, CH_W+3+32+TS_W, record width (derived localparam)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- enable  in  1  capture and timestamp enable
- clear  in  1  synchronous clear of timestamp, holds, FIFO, ovf, drop_cnt
- tok_in  in  36*NUM_CH  channel k occupies [36k+35:36k]; token format {vbl[2:0], ctrl, value[31:0]}
- rd_valid  out  1  FIFO not empty
- rd_ready  in  1  consumer accepts the head record
- rd_data  out  REC_W  head record {ch_id, vbl, value, timestamp}, MSB first
- fill  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf  out  NUM_CH  sticky per-channel drop flags
- drop_cnt  out  16  saturating total of dropped tokens

Behaviour:
- Reset (reset=0, asynchronous): all outputs, holds, pointers and counters go to 0; rd_data=0.
- Timestamp counter:
  - ts increments every cycle while enable=1, holds while enable=0, wraps modulo 2^TS_W.
  - clear forces ts=0.
  - clear has priority over all other updates in the same cycle.
- Qualify: channel k qualifies at edge E when enable=1, vbl!=3'b000 and ctrl==0. A token is sampled once per edge.
- Holding registers:
  - One per channel, storing {vbl, value, ts} with ts taken pre-increment at E.
  - If a hold is occupied and not granted at E, a new qualifying token on that channel is dropped: ovf[k]<=1 and drop_cnt increases by the number of channels dropped at E, saturating at 16'hFFFF.
  - A hold granted at E may be refilled by a token at E, so there is no drop.
- Arbiter:
  - At each edge where the FIFO is not full (judged at cycle start), grant the first occupied hold at or after rr_ptr.
  - Write {k, hold} into the FIFO, free the hold, set rr_ptr=k+1 modulo NUM_CH.
  - Full FIFO: no grant, holds stay, no bypass.
- Latency: a token sampled at E0 with an empty FIFO and idle arbiter is written at E1. rd_valid is high after E1 (2 edges from bus to visible).
- FIFO:
  - First-word-fall-through; rd_data shows the head combinationally from registered storage.
  - Pop when rd_valid && rd_ready.
  - Simultaneous push and pop is legal at any non-full occupancy. fill is unchanged in that case.
  - Pointers wrap modulo DEPTH.
- enable low: no new captures. Existing holds and the FIFO continue to drain.
- clear: empties holds and the FIFO at the next edge; in-flight tokens are discarded.

Optional Feature:
- Macro: TRACE_CHAN_MASK_EN.
- Defined: adds input chan_mask[NUM_CH]. A channel with chan_mask[k]=1 never qualifies. A mask change takes effect at the next edge; the existing hold is still drained.
- Undefined: no port; all channels are monitored.

Decomposition:
- Package pe_trace_pkg holds:
  - token field localparams: VBL_HI=35, VBL_LO=33, CTRL_BIT=32, VAL_HI=31
  - TOKEN_W=36
  - a trace_rec_t typedef helper and a drop-count width constant.
- Sub-module pe_trace_fifo: parametrised width/depth FWFT FIFO with fill output, reused by other debug blocks.
- Arbiter and holds remain in the top.

Test Plan:
- Reset and single token: reset low then high; ch2 token {3'b110,0,32'd7} at ts=5 -> after 2 edges rd_valid=1, rd_data={2,3'b110,7,5}; pop -> fill=0.
- Filter: ch0 token with ctrl=1 or vbl=3'b000 -> no record, fill stays 0.
- Simultaneous events: ch1, ch3, ch6 all qualify at one edge with rr_ptr=2 -> records in order ch3, ch6, ch1 on consecutive cycles.
- FIFO full with DEPTH=4 and rd_ready=0: feed ch0 every cycle -> fill=4, then ovf[0]=1 and drop_cnt increments by 1 per cycle; raise rd_ready -> records drain in order with timestamps strictly increasing.
- Timestamp wrap with TS_W=4: tokens at ts 15 and 0 -> records carry 15 and then 0. Also assert clear mid-stream -> fill=0, ovf=0, drop_cnt=0, next record ts starts from 0.
- Mask (TRACE_CHAN_MASK_EN): chan_mask=8'h01 with tokens on ch0 and ch1 in the same cycle -> only the ch1 record appears.

Source files
------------

// File: rtl/pe_trace_pkg.sv
// Shared token field layout and record helpers for the PE trace capture unit.
package pe_trace_pkg;

  localparam int TOKEN_W    = 36;
  localparam int VBL_HI     = 35;
  localparam int VBL_LO     = 33;
  localparam int CTRL_BIT   = 32;
  localparam int VAL_HI     = 31;
  localparam int DROP_CNT_W = 16;

  // Width-independent core of a trace record; channel id and timestamp wrap it.
  typedef struct packed {
    logic [2:0]  vbl;
    logic [31:0] value;
  } trace_rec_t;

  function automatic trace_rec_t tok_payload(input logic [TOKEN_W-1:0] tok);
    trace_rec_t rec;
    rec.vbl   = tok[VBL_HI:VBL_LO];
    rec.value = tok[VAL_HI:0];
    return rec;
  endfunction

  function automatic logic tok_qualifies(input logic [TOKEN_W-1:0] tok);
    return (tok[VBL_HI:VBL_LO] != 3'b000) && !tok[CTRL_BIT];
  endfunction

endpackage

// File: rtl/pe_trace_fifo.sv
// First-word-fall-through FIFO with occupancy output; head is shown straight from storage.
module pe_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      fill,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push;
  logic             pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign rd_valid = (count_reg != '0);
  assign fill     = count_reg;
  assign push     = wr_en && !full;
  assign pop      = rd_valid && rd_ready;
  // Empty FIFO presents zero so the head never exposes stale storage.
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pe_trace_capture.sv
// Captures qualifying PE_Outport0 tokens with channel id and timestamp into a trace FIFO.
// Optional per-channel masking is built when TRACE_CHAN_MASK_EN is defined.
module pe_trace_capture
  import pe_trace_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DEPTH  = 64,
  parameter int TS_W   = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int REC_W = CH_W + 3 + 32 + TS_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [TOKEN_W*NUM_CH-1:0] tok_in,
`ifdef TRACE_CHAN_MASK_EN
  input  logic [NUM_CH-1:0]         chan_mask,
`endif
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [REC_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]    fill,
  output logic [NUM_CH-1:0]         ovf,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  localparam int HOLD_W = 35 + TS_W;

  logic [TS_W-1:0]       ts_reg;
  logic [CH_W-1:0]       rr_ptr_reg;
  logic                  hold_valid_reg [NUM_CH];
  logic [HOLD_W-1:0]     hold_data_reg  [NUM_CH];
  logic [NUM_CH-1:0]     ovf_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  logic [NUM_CH-1:0]     qualify;
  logic [NUM_CH-1:0]     grant_onehot;
  logic [NUM_CH-1:0]     drop_vec;
  logic                  grant_valid;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W-1:0]       rr_ptr_next;
  logic                  fifo_full;
  logic [5:0]            n_drop;
  logic [DROP_CNT_W:0]   drop_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
`ifdef TRACE_CHAN_MASK_EN
      assign qualify[gi] = enable && !chan_mask[gi] && tok_qualifies(tok_in[gi*TOKEN_W +: TOKEN_W]);
`else
      assign qualify[gi] = enable && tok_qualifies(tok_in[gi*TOKEN_W +: TOKEN_W]);
`endif
      assign grant_onehot[gi] = grant_valid && (grant_idx == CH_W'(gi));
      // A granted hold frees this edge, so a new token refills it instead of dropping.
      assign drop_vec[gi] = qualify[gi] && hold_valid_reg[gi] && !grant_onehot[gi];
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_valid && !fifo_full && hold_valid_reg[CH_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  assign rr_ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  assign n_drop      = 6'($countones(drop_vec));
  assign drop_sum    = {1'b0, drop_cnt_reg} + (DROP_CNT_W+1)'(n_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_reg       <= '0;
      rr_ptr_reg   <= '0;
      ovf_reg      <= '0;
      drop_cnt_reg <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        hold_valid_reg[k] <= 1'b0;
        hold_data_reg[k]  <= '0;
      end
    end else if (clear) begin
      ts_reg       <= '0;
      ovf_reg      <= '0;
      drop_cnt_reg <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        hold_valid_reg[k] <= 1'b0;
      end
    end else begin
      if (enable) ts_reg <= ts_reg + 1'b1;
      if (grant_valid) rr_ptr_reg <= rr_ptr_next;
      ovf_reg      <= ovf_reg | drop_vec;
      drop_cnt_reg <= drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
      for (int k = 0; k < NUM_CH; k++) begin
        if (qualify[k] && (!hold_valid_reg[k] || grant_onehot[k])) begin
          hold_valid_reg[k] <= 1'b1;
          hold_data_reg[k]  <= {tok_payload(tok_in[k*TOKEN_W +: TOKEN_W]), ts_reg};
        end else if (grant_onehot[k]) begin
          hold_valid_reg[k] <= 1'b0;
        end
      end
    end
  end

  pe_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (grant_valid),
    .wr_data  ({grant_idx, hold_data_reg[grant_idx]}),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .fill     (fill),
    .full     (fifo_full)
  );

  assign ovf      = ovf_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_pe_trace_capture.sv
// Self-checking bench for pe_trace_capture: directed scenarios plus randomized traffic vs a queue model.
module tb_pe_trace_capture;

  localparam int NUM_CH = 8;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 4;
  localparam int CH_W   = 3;
  localparam int REC_W  = CH_W + 3 + 32 + TS_W;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic                 clear;
  logic [36*NUM_CH-1:0] tok_in;
  logic [NUM_CH-1:0]    chan_mask;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [REC_W-1:0]     rd_data;
  logic [2:0]           fill;
  logic [NUM_CH-1:0]    ovf;
  logic [15:0]          drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit               m_hv [NUM_CH];
  logic [38:0]      m_hd [NUM_CH];
  logic [REC_W-1:0] m_q [$];
  int               m_ts, m_rr, m_drop;
  logic [NUM_CH-1:0] m_ovf;

  pe_trace_capture #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (clear),
    .tok_in   (tok_in),
`ifdef TRACE_CHAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .fill     (fill),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_hv[k] = 0;
      m_hd[k] = '0;
    end
    m_q.delete();
    m_ts = 0; m_rr = 0; m_drop = 0; m_ovf = '0;
  endtask

  task automatic model_step();
    int sz, g, nd;
    logic [35:0] tok;
    if (!reset) begin
      model_reset();
      return;
    end
    if (clear) begin
      m_ts = 0; m_ovf = '0; m_drop = 0;
      for (int k = 0; k < NUM_CH; k++) m_hv[k] = 0;
      m_q.delete();
      return;
    end
    sz = m_q.size();
    g  = -1;
    if (sz < DEPTH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (g < 0 && m_hv[(m_rr + i) % NUM_CH]) g = (m_rr + i) % NUM_CH;
      end
    end
    if (sz > 0 && rd_ready) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({3'(g), m_hd[g]});
      m_hv[g] = 0;
      m_rr = (g + 1) % NUM_CH;
    end
    nd = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      tok = tok_in[k*36 +: 36];
      if (enable && tok[35:33] != 3'b000 && !tok[32] && !chan_mask[k]) begin
        if (m_hv[k]) begin
          nd++;
          m_ovf[k] = 1'b1;
        end else begin
          m_hv[k] = 1;
          m_hd[k] = {tok[35:33], tok[31:0], 4'(m_ts)};
        end
      end
    end
    m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
    if (enable) m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic compare_all();
    logic [REC_W-1:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    chk("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
    chk("fill", 64'(fill), 64'(m_q.size()));
    chk("rd_data", 64'(rd_data), 64'(head));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_tok(input int ch, input logic [2:0] vbl, input logic ctrl, input logic [31:0] val);
    tok_in[ch*36 +: 36] = {vbl, ctrl, val};
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    tok_in = '0; chan_mask = '0;
    model_reset();
    #2 reset = 1'b0;
    #1 compare_all();
    repeat (2) tick();
    @(negedge clk) reset = 1'b1;

    // Single token on ch2 at ts=5
    enable = 1'b1;
    repeat (5) tick();
    set_tok(2, 3'b110, 1'b0, 32'd7);
    tick();
    tok_in = '0;
    chk("single_not_yet_visible", 64'(rd_valid), 64'd0);
    tick();
    chk("single_rec", 64'(rd_data), 64'({3'd2, 3'b110, 32'd7, 4'd5}));
    rd_ready = 1'b1;
    tick();
    chk("single_popped_fill", 64'(fill), 64'd0);

    // Filtered tokens: ctrl set, vbl zero
    set_tok(0, 3'b101, 1'b1, 32'h11);
    tick();
    set_tok(0, 3'b000, 1'b0, 32'h22);
    tick();
    tok_in = '0;
    repeat (2) tick();
    chk("filter_fill", 64'(fill), 64'd0);

    // Round robin: ch1 grant moves pointer to 2, then ch1/ch3/ch6 together
    set_tok(1, 3'b001, 1'b0, 32'h100);
    tick();
    tok_in = '0;
    repeat (2) tick();
    set_tok(1, 3'b011, 1'b0, 32'h1);
    set_tok(3, 3'b011, 1'b0, 32'h3);
    set_tok(6, 3'b011, 1'b0, 32'h6);
    tick();
    tok_in = '0;
    tick();
    chk("rr_first_ch3", 64'(rd_data[REC_W-1 -: CH_W]), 64'd3);
    tick();
    chk("rr_second_ch6", 64'(rd_data[REC_W-1 -: CH_W]), 64'd6);
    tick();
    chk("rr_third_ch1", 64'(rd_data[REC_W-1 -: CH_W]), 64'd1);
    repeat (2) tick();

    // FIFO full with no reader: drops on ch0
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_tok(0, 3'b111, 1'b0, 32'(100 + i));
      tick();
    end
    chk("full_fill", 64'(fill), 64'd4);
    chk("full_ovf0", 64'(ovf[0]), 64'd1);
    tok_in = '0;
    rd_ready = 1'b1;
    repeat (7) tick();

    // Timestamp wrap: tokens at ts 15 then 0
    for (int i = 0; i < 16 && m_ts != 15; i++) tick();
    set_tok(4, 3'b010, 1'b0, 32'hAAAA);
    tick();
    tok_in = '0;
    set_tok(5, 3'b010, 1'b0, 32'hBBBB);
    tick();
    tok_in = '0;
    chk("wrap_ts15", 64'(rd_data[TS_W-1:0]), 64'd15);
    tick();
    chk("wrap_ts0", 64'(rd_data[TS_W-1:0]), 64'd0);
    repeat (2) tick();

    // Clear mid-stream after building up drops
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_tok(i % 2, 3'b100, 1'b0, 32'(i));
      set_tok(7, 3'b100, 1'b0, 32'(i + 50));
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tok_in = '0;
    chk("clear_fill", 64'(fill), 64'd0);
    chk("clear_ovf", 64'(ovf), 64'd0);
    chk("clear_drop", 64'(drop_cnt), 64'd0);
    set_tok(3, 3'b001, 1'b0, 32'h5);
    tick();
    tok_in = '0;
    tick();
    chk("clear_ts_restart", 64'(rd_data[TS_W-1:0]), 64'd0);
    rd_ready = 1'b1;
    repeat (2) tick();

`ifdef TRACE_CHAN_MASK_EN
    chan_mask = 8'h01;
    set_tok(0, 3'b001, 1'b0, 32'hC0);
    set_tok(1, 3'b001, 1'b0, 32'hC1);
    tick();
    tok_in = '0;
    tick();
    chk("mask_only_ch1", 64'(rd_data[REC_W-1 -: CH_W]), 64'd1);
    tick();
    chk("mask_no_ch0", 64'(fill), 64'd0);
    chan_mask = '0;
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      enable   = ($urandom_range(0, 7) != 0);
      clear    = ($urandom_range(0, 59) == 0);
      rd_ready = ($urandom_range(0, 2) != 0);
`ifdef TRACE_CHAN_MASK_EN
      if ($urandom_range(0, 19) == 0) chan_mask = NUM_CH'($urandom);
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 3) == 0)
          set_tok(k, 3'($urandom), ($urandom_range(0, 3) == 0), $urandom);
        else
          set_tok(k, 3'b000, 1'b0, 32'd0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
